// File: rtl/bmux_4_comb.sv
// rtl/bmux_4_comb.sv - pure combinational 4:1 mux with one-hot select decode
module bmux_4_comb #(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] r,
  output logic [3:0]       sel_oh
);

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  // The X default lets an unknown select propagate instead of favouring one input.
  always_comb begin
    r = 'x;
    case (s)
      SEL_A:   r = A;
      SEL_B:   r = B;
      SEL_C:   r = C;
      SEL_D:   r = D;
      default: r = 'x;
    endcase
  end

  assign sel_oh = {s == SEL_D, s == SEL_C, s == SEL_B, s == SEL_A};

endmodule

// File: rtl/bmux_4.sv
// rtl/bmux_4.sv - 4:1 mux with combinational result and a registered copy
module bmux_4 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] r,
  output logic [3:0]       sel_oh,
  output logic [WIDTH-1:0] r_q,
  output logic             r_q_valid
);

  bmux_4_comb #(.WIDTH(WIDTH)) u_comb (
    .s      (s),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .r      (r),
    .sel_oh (sel_oh)
  );

  // Reset only touches the register stage; r and sel_oh keep tracking inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q       <= r;
      r_q_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bmux_4.sv
// tb/tb_bmux_4.sv - self-checking scoreboard bench for bmux_4
module tb_bmux_4;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [1:0]   s;
  logic [W-1:0] A, B, C, D;
  logic [W-1:0] r;
  logic [3:0]   sel_oh;
  logic [W-1:0] r_q;
  logic         r_q_valid;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  bmux_4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .r         (r),
    .sel_oh    (sel_oh),
    .r_q       (r_q),
    .r_q_valid (r_q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mux(input logic [1:0] sel, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] c,
                                           input logic [W-1:0] d);
    logic [W-1:0] v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v[sel];
  endfunction

  task automatic pop_check(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, r_q, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s = 2'd0;
    A = '0; B = '0; C = '0; D = '0;
    #2;
    check_eq("reset_r_q", r_q, 0);
    check_eq("reset_valid", r_q_valid, 0);

    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1;
      check_eq("zero_data_r", r, 0);
      check_eq("zero_data_oh", sel_oh, 32'(1 << i));
    end

    A = 16'd1; B = 16'd2; C = 16'd3; D = 16'd4;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1;
      check_eq("step_r", r, 32'(i + 1));
      check_eq("step_oh", sel_oh, 32'(1 << i));
    end

    A = 16'hFFFF; B = 16'h0000; C = 16'hA5A5; D = 16'h5A5A;
    s = 2'd3;
    #1;
    check_eq("wrap_pre_r", r, 32'h5A5A);
    s = s + 2'd1;
    #1;
    check_eq("wrap_post_r", r, 32'hFFFF);
    check_eq("wrap_post_oh", sel_oh, 32'h1);

    s = 2'd2; C = 16'd3;
    #1;
    check_eq("in_reset_r", r, 3);
    check_eq("in_reset_r_q", r_q, 0);
    check_eq("in_reset_valid", r_q_valid, 0);

    @(negedge clk);
    rst_n = 1'b1;
    s = 2'd1; B = 16'd2;
    #1;
    check_eq("pre_edge_valid", r_q_valid, 0);
    exp_q.push_back(16'd2);
    @(posedge clk); #1;
    pop_check("first_edge_r_q");
    check_eq("first_edge_valid", r_q_valid, 1);

    s = 2'd3; D = 16'd4;
    #1;
    check_eq("comb_immediate_r", r, 4);
    check_eq("r_q_holds", r_q, 2);
    exp_q.push_back(16'd4);
    @(posedge clk); #1;
    pop_check("second_edge_r_q");

    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_r_q", r_q, 0);
    check_eq("async_rst_valid", r_q_valid, 0);
    check_eq("rst_r_tracks", r, 4);
    s = 2'd0; A = 16'hBEEF;
    #1;
    check_eq("rst_r_tracks2", r, 32'hBEEF);
    check_eq("rst_oh_tracks", sel_oh, 1);
    @(posedge clk); #1;
    check_eq("held_rst_r_q", r_q, 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 24; n++) begin
      s = 2'($urandom_range(0, 3));
      A = 16'($urandom); B = 16'($urandom);
      C = 16'($urandom); D = 16'($urandom);
      #1;
      check_eq("rand_comb_r", r, ref_mux(s, A, B, C, D));
      // Late change close to the edge: register must see these values.
      #2;
      s = s + 2'd1;
      D = ~D;
      exp_q.push_back(ref_mux(s, A, B, C, D));
      @(posedge clk); #1;
      pop_check("rand_r_q");
      check_eq("rand_valid", r_q_valid, 1);
      @(negedge clk);
    end

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmux_4.md
BMUX_4 -- requirements
Module: bmux_4

Interface
REQ-001 Parameter WIDTH, default 16: data width of A, B, C, D, r and r_q.
REQ-002 Port clk, input, 1: single clock; every register updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset is asynchronous and active-low.
REQ-004 Port s, input, 2: select code; 0 picks A, 1 picks B, 2 picks C, 3 picks D.
REQ-005 Port A, input, WIDTH: data input 0.
REQ-006 Port B, input, WIDTH: data input 1.
REQ-007 Port C, input, WIDTH: data input 2.
REQ-008 Port D, input, WIDTH: data input 3.
REQ-009 Port r, output, WIDTH: combinational mux result.
REQ-010 Port sel_oh, output, 4: combinational one-hot decode of s; bit k is set when s==k.
REQ-011 Port r_q, output, WIDTH: registered copy of r.
REQ-012 Port r_q_valid, output, 1: r_q holds a value captured since the last reset.

Function
REQ-013 r SHALL equal A/B/C/D for s=0/1/2/3, as a purely combinational function of s and the data inputs.
- No clock edge is needed for r to settle.
- r SHALL be independent of clk and rst_n.
REQ-014 r SHALL settle within one simulation time unit of any change on s, A, B, C or D.
REQ-015 Selection SHALL be full-width and bit-exact: no sign extension, truncation or arithmetic on data.
REQ-016 s is a 2-bit value, so all four codes are legal.
- A 3->0 wrap of s (increment overflow) SHALL select A with no special handling.
REQ-017 sel_oh SHALL be exactly one-hot for every legal s (0001, 0010, 0100, 1000 for s=0..3), combinational.
REQ-018 r_q SHALL capture r on each rising clk edge while rst_n is high, giving 1-cycle latency.
REQ-019 r_q_valid SHALL go to 1 on the first rising edge after reset release and stay 1 until the next reset.
REQ-020 Simultaneous change of s and data before a clock edge: r_q SHALL capture the mux result of the values present at that edge.
REQ-021 With any input bit of s at X/Z, r SHALL be X (no latch inferred, no priority default).

Reset
REQ-022 When rst_n goes low, r_q SHALL clear to 0 and r_q_valid to 0 immediately, without waiting for clk.
REQ-023 Reset asserted mid-operation SHALL clear the registered outputs only; r and sel_oh SHALL keep tracking their inputs during reset.
REQ-024 Reset release SHALL take effect on the first rising clk edge that follows rst_n going high.

Structure
REQ-025 No shared package is needed; WIDTH stays a module parameter.
- The select codes SEL_A=0, SEL_B=1, SEL_C=2, SEL_D=3 SHALL be localparams.
REQ-026 Sub-module: one natural sub-module, bmux_4_comb, holding the pure combinational 4:1 mux and one-hot decode.
- The top level wraps bmux_4_comb with the output register.

Verification
REQ-027 All data inputs 0, s stepped 0,1,2,3 with 1 time unit between steps -> r==0 at every step.
REQ-028 A=1, B=2, C=3, D=4, s stepped 0..3 with 1 time unit each -> r==s+1 each step (1,2,3,4); sel_oh==1<<s.
REQ-029 A=16'hFFFF, B=16'h0000, C=16'hA5A5, D=16'h5A5A, s=3 then incremented -> r==16'h5A5A, then 16'hFFFF after the wrap to s=0.
REQ-030 rst_n low with s=2, C=3 -> r==3 immediately; r_q==0 and r_q_valid==0 with no clock edges.
REQ-031 Release reset, s=1, B=2, one rising edge -> r_q==2, r_q_valid==1; change s to 3, D=4 -> r==4 at once and r_q==4 only after the next edge.
REQ-032 Assert rst_n low between clock edges while r_q==4 -> r_q==0 and r_q_valid==0 before the next edge.
